// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO write port.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] highresult,
    output logic [WIDTH-1:0] lowresult,
    output logic             hilowrite
);

    localparam int CW = $clog2(WIDTH + 1);

    // Handshake: start is only looked at in IDLE; done/hilowrite pulse for the
    // single DONE cycle, and a new start is taken from the following IDLE cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_main_q, neg_main_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last_step;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign signed_op = ~op[0];
    assign a_mag     = (signed_op && srcA[WIDTH-1]) ? -srcA : srcA;
    assign b_mag     = (signed_op && srcB[WIDTH-1]) ? -srcB : srcB;
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // Multiply: accumulator is {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: accumulator is {partial remainder, dividend bits / quotient bits}.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_step  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_main_q ? -acc_q : acc_q;
    assign quo_fix  = neg_main_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (last_step) state_d = S_SIGN;
            S_SIGN:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        hilowrite = (state_q == S_DONE);
    end

    // Datapath next-state
    always_comb begin
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        opnd_d     = opnd_q;
        a_raw_d    = a_raw_q;
        acc_d      = acc_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d      = '0;
                    is_div_d   = op[1];
                    neg_main_d = signed_op & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
                    neg_rem_d  = signed_op & op[1] & srcA[WIDTH-1];
                    div_zero_d = op[1] & (srcB == '0);
                    a_raw_d    = srcA;
                    opnd_d     = op[1] ? b_mag : a_mag;
                    acc_d      = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = is_div_q ? div_step : mul_step;
            end
            S_SIGN: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div_zero_q) begin
                    // No trap on divide by zero: hand back the dividend untouched.
                    hi_d = a_raw_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            acc_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            opnd_q     <= opnd_d;
            a_raw_q    <= a_raw_d;
            acc_q      <= acc_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign highresult = hi_q;
    assign lowresult  = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops checked
// against a 64-bit integer arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  srcA;
    logic [W-1:0]  srcB;
    logic          busy;
    logic          done;
    logic [W-1:0]  highresult;
    logic [W-1:0]  lowresult;
    logic          hilowrite;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    mult_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .srcA       (srcA),
        .srcB       (srcB),
        .busy       (busy),
        .done       (done),
        .highresult (highresult),
        .lowresult  (lowresult),
        .hilowrite  (hilowrite)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference model: {HI, LO} from plain 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0000_0000;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Called just after the start-sampling edge; checks latency, pulse and result.
    task automatic wait_done(input string tag);
        int cyc;
        bit seen;
        bit busy_ok;
        bit early_wr;
        logic [63:0] exp;
        cyc = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        early_wr = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else begin
                if (!busy) busy_ok = 1'b0;
                if (hilowrite) early_wr = 1'b1;
            end
        end
        exp = exp_q.pop_front();
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(cyc), 64'(W + 1));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_wr_early"}, 64'(early_wr), 64'd0);
        check({tag, "_hlw"}, 64'(hilowrite), 64'd1);
        check({tag, "_hilo"}, {highresult, lowresult}, exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_pulse"}, {62'd0, done, hilowrite}, 64'd0);
        check({tag, "_hold"}, {highresult, lowresult}, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        exp_q.push_back(model(o, a, b));
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        bit wr_seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srcA  = '0;
        srcB  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {61'd0, busy, done, hilowrite}, 64'd0);
        check("rst_hilo", {highresult, lowresult}, 64'd0);

        // Directed corners
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_const", {highresult, lowresult}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        check("mult_neg_const", {highresult, lowresult}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_neg_const", {highresult, lowresult}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7);
        check("divu_const", {highresult, lowresult}, 64'h0000_0002_0000_000E);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {highresult, lowresult}, 64'h0000_0000_8000_0000);
        run_op("divu_zero", 2'b11, 32'h1234_5678, 32'h0);
        check("divu_zero_const", {highresult, lowresult}, 64'h1234_5678_FFFF_FFFF);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'h0);

        // start held high through an operation with changing operands
        exp_q.push_back(model(2'b11, 32'd1000, 32'd9));
        exp_q.push_back(model(2'b00, 32'hFFFF_FFF0, 32'd3));
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        srcA  = 32'd1000;
        srcB  = 32'd9;
        @(posedge clk);
        #1;
        op   = 2'b00;
        srcA = 32'hFFFF_FFF0;
        srcB = 32'd3;
        wait_done("hold_first");
        check("hold_idle_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("hold_second");

        // Reset in the middle of a calculation
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        srcA  = 32'hDEAD_BEEF;
        srcB  = 32'h1234_5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_ctrl", {61'd0, busy, done, hilowrite}, 64'd0);
        check("abort_hilo", {highresult, lowresult}, 64'd0);
        rst = 1'b0;
        wr_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (hilowrite || busy) wr_seen = 1'b1;
        end
        check("abort_quiet", 64'(wr_seen), 64'd0);
        run_op("after_abort", 2'b01, 32'd7, 32'd6);
        check("after_abort_const", {highresult, lowresult}, 64'h0000_0000_0000_002A);

        // Random operations with occasional idle gaps
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
